// File: rtl/data_bus_segments.sv
// Registered three-segment internal data bus (db0/db1/db2) with SW1/SW2
// switches, keeper registers, bits [5:3] mask on SW1 down, contention debug.
//
// Ports:
//   clk, reset            : core clock, synchronous active-high reset
//   bus_sw_1u/1d/2u/2d    : switch direction enables (1: db0-db1, 2: db1-db2)
//   bus_sw_mask543_en     : clear bits [5:3] on the db0->db1 hop
//   db{0,1,2}_in/_oe      : local driver value / enable per segment
//   db{0,1,2}_out         : registered resolved segment values
//   contention            : one-cycle pulse after a contended cycle
//   contention_cnt        : saturating count of contended cycles
module data_bus_segments (
    input  logic       clk,
    input  logic       reset,
    input  logic       bus_sw_1u,
    input  logic       bus_sw_1d,
    input  logic       bus_sw_2u,
    input  logic       bus_sw_2d,
    input  logic       bus_sw_mask543_en,
    input  logic [7:0] db0_in,
    input  logic [7:0] db1_in,
    input  logic [7:0] db2_in,
    input  logic       db0_oe,
    input  logic       db1_oe,
    input  logic       db2_oe,
    output logic [7:0] db0_out,
    output logic [7:0] db1_out,
    output logic [7:0] db2_out,
    output logic       contention,
    output logic [7:0] contention_cnt
);

    // Downstream chain
    logic       d1_valid;
    logic [7:0] d1_val;
    logic [7:0] d0_masked;
    // Upstream chain
    logic       u1_valid;
    logic       u0_valid;
    logic [7:0] u0_val;
    // Per-segment candidates from the switches
    logic       seg1_dn_v;
    logic       seg2_dn_v;
    logic       seg0_up_v;
    logic       seg1_up_v;
    // Next-state
    logic [7:0] db0_nxt;
    logic [7:0] db1_nxt;
    logic [7:0] db2_nxt;
    logic       cont0;
    logic       cont1;
    logic       cont2;
    logic       cont_any;

    always_comb begin
        d0_masked = db0_in;
        if (bus_sw_mask543_en) begin
            d0_masked[5:3] = 3'b000;
        end
    end

    // Downstream: D1 is db1's own driver, else masked db0 through SW1.
    assign seg1_dn_v = bus_sw_1d & db0_oe;
    assign d1_valid  = db1_oe | seg1_dn_v;
    assign d1_val    = db1_oe ? db1_in : d0_masked;
    assign seg2_dn_v = bus_sw_2d & d1_valid;

    // Upstream: never masked.
    assign u1_valid  = bus_sw_2u & db2_oe;
    assign u0_valid  = bus_sw_1u & (db1_oe | u1_valid);
    assign u0_val    = db1_oe ? db1_in : db2_in;
    assign seg1_up_v = u1_valid;
    assign seg0_up_v = u0_valid;

    always_comb begin
        db0_nxt = db0_out;
        if (db0_oe) begin
            db0_nxt = db0_in;
        end else if (seg0_up_v) begin
            db0_nxt = u0_val;
        end
    end

    always_comb begin
        db1_nxt = db1_out;
        if (db1_oe) begin
            db1_nxt = db1_in;
        end else if (seg1_dn_v) begin
            db1_nxt = d0_masked;
        end else if (seg1_up_v) begin
            db1_nxt = db2_in;
        end
    end

    always_comb begin
        db2_nxt = db2_out;
        if (db2_oe) begin
            db2_nxt = db2_in;
        end else if (seg2_dn_v) begin
            db2_nxt = d1_val;
        end
    end

    // Two or more of {own, down, up}; db0 has no down, db2 has no up.
    assign cont0    = db0_oe & seg0_up_v;
    assign cont1    = (db1_oe & seg1_dn_v) | (db1_oe & seg1_up_v)
                    | (seg1_dn_v & seg1_up_v);
    assign cont2    = db2_oe & seg2_dn_v;
    assign cont_any = cont0 | cont1 | cont2;

    always_ff @(posedge clk) begin
        if (reset) begin
            db0_out        <= 8'hFF;
            db1_out        <= 8'hFF;
            db2_out        <= 8'hFF;
            contention     <= 1'b0;
            contention_cnt <= 8'h00;
        end else begin
            db0_out    <= db0_nxt;
            db1_out    <= db1_nxt;
            db2_out    <= db2_nxt;
            contention <= cont_any;
            if (cont_any && (contention_cnt != 8'hFF)) begin
                contention_cnt <= contention_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_data_bus_segments.sv
// Testbench for data_bus_segments: directed vector table, saturation and
// mid-run reset sequence, then random stimulus against a segment-chain model.
module tb_data_bus_segments;

    logic       clk = 1'b0;
    logic       reset;
    logic       bus_sw_1u, bus_sw_1d, bus_sw_2u, bus_sw_2d;
    logic       bus_sw_mask543_en;
    logic [7:0] db0_in, db1_in, db2_in;
    logic       db0_oe, db1_oe, db2_oe;
    logic [7:0] db0_out, db1_out, db2_out;
    logic       contention;
    logic [7:0] contention_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_bus_segments dut (
        .clk               (clk),
        .reset             (reset),
        .bus_sw_1u         (bus_sw_1u),
        .bus_sw_1d         (bus_sw_1d),
        .bus_sw_2u         (bus_sw_2u),
        .bus_sw_2d         (bus_sw_2d),
        .bus_sw_mask543_en (bus_sw_mask543_en),
        .db0_in            (db0_in),
        .db1_in            (db1_in),
        .db2_in            (db2_in),
        .db0_oe            (db0_oe),
        .db1_oe            (db1_oe),
        .db2_oe            (db2_oe),
        .db0_out           (db0_out),
        .db1_out           (db1_out),
        .db2_out           (db2_out),
        .contention        (contention),
        .contention_cnt    (contention_cnt)
    );

    // sw = {1u, 1d, 2u, 2d, mask}
    typedef struct {
        logic       rst;
        logic [4:0] sw;
        logic [2:0] oe;
        logic [7:0] d0, d1, d2;
        logic [7:0] e0, e1, e2;
        logic       ec;
        logic [7:0] ecnt;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(logic rst, logic [4:0] sw, logic [2:0] oe,
                                logic [7:0] d0, logic [7:0] d1, logic [7:0] d2,
                                logic [7:0] e0, logic [7:0] e1, logic [7:0] e2,
                                logic ec, logic [7:0] ecnt);
        vec_t v;
        v.rst = rst; v.sw = sw; v.oe = oe;
        v.d0 = d0; v.d1 = d1; v.d2 = d2;
        v.e0 = e0; v.e1 = e1; v.e2 = e2;
        v.ec = ec; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h @%0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic drive(input logic rst, input logic [4:0] sw,
                         input logic [2:0] oe, input logic [7:0] d0,
                         input logic [7:0] d1, input logic [7:0] d2);
        reset = rst;
        {bus_sw_1u, bus_sw_1d, bus_sw_2u, bus_sw_2d, bus_sw_mask543_en} = sw;
        {db2_oe, db1_oe, db0_oe} = oe;
        db0_in = d0; db1_in = d1; db2_in = d2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: segments 0..2, switch k joins segment k and k+1.
    logic [7:0] m_db[3];
    logic       m_cont;
    int         m_cnt;

    task automatic model_clock();
        logic       own[3];
        logic [7:0] din[3];
        logic       sw_u[2], sw_d[2];
        logic       dv[3], uv[3];
        logic [7:0] dval[3], uval[3];
        logic       dn_c[3], up_c[3];
        logic [7:0] dn_x[3], up_x[3];
        logic       any;
        int         n;
        own[0] = db0_oe; own[1] = db1_oe; own[2] = db2_oe;
        din[0] = db0_in; din[1] = db1_in; din[2] = db2_in;
        sw_d[0] = bus_sw_1d; sw_d[1] = bus_sw_2d;
        sw_u[0] = bus_sw_1u; sw_u[1] = bus_sw_2u;
        for (int k = 0; k < 3; k++) begin
            dn_c[k] = 1'b0; dn_x[k] = 8'h00;
            if (k > 0 && sw_d[k-1] && dv[k-1]) begin
                dn_c[k] = 1'b1;
                dn_x[k] = dval[k-1];
                if (k == 1 && bus_sw_mask543_en) dn_x[k] &= 8'hC7;
            end
            dv[k]   = own[k] || dn_c[k];
            dval[k] = own[k] ? din[k] : dn_x[k];
        end
        for (int k = 2; k >= 0; k--) begin
            up_c[k] = 1'b0; up_x[k] = 8'h00;
            if (k < 2 && sw_u[k] && uv[k+1]) begin
                up_c[k] = 1'b1;
                up_x[k] = uval[k+1];
            end
            uv[k]   = own[k] || up_c[k];
            uval[k] = own[k] ? din[k] : up_x[k];
        end
        any = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n = int'(own[k]) + int'(dn_c[k]) + int'(up_c[k]);
            if (n >= 2) any = 1'b1;
        end
        if (reset) begin
            m_db[0] = 8'hFF; m_db[1] = 8'hFF; m_db[2] = 8'hFF;
            m_cont = 1'b0; m_cnt = 0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (own[k])       m_db[k] = din[k];
                else if (dn_c[k]) m_db[k] = dn_x[k];
                else if (up_c[k]) m_db[k] = up_x[k];
            end
            m_cont = any;
            if (any && m_cnt < 255) m_cnt++;
        end
    endtask

    initial begin
        vecs[0]  = mk(1, 5'b00000, 3'b000, 8'h00, 8'h00, 8'h00,
                      8'hFF, 8'hFF, 8'hFF, 0, 8'd0);
        vecs[1]  = mk(0, 5'b00000, 3'b000, 8'h00, 8'h00, 8'h00,
                      8'hFF, 8'hFF, 8'hFF, 0, 8'd0);
        vecs[2]  = mk(0, 5'b00000, 3'b010, 8'h00, 8'h3C, 8'h00,
                      8'hFF, 8'h3C, 8'hFF, 0, 8'd0);
        vecs[3]  = mk(0, 5'b00000, 3'b000, 8'h00, 8'h00, 8'h00,
                      8'hFF, 8'h3C, 8'hFF, 0, 8'd0);
        vecs[4]  = mk(0, 5'b01011, 3'b001, 8'hFF, 8'h00, 8'h00,
                      8'hFF, 8'hC7, 8'hC7, 0, 8'd0);
        vecs[5]  = mk(0, 5'b01010, 3'b001, 8'hFF, 8'h00, 8'h00,
                      8'hFF, 8'hFF, 8'hFF, 0, 8'd0);
        vecs[6]  = mk(0, 5'b10101, 3'b100, 8'h00, 8'h00, 8'h5A,
                      8'h5A, 8'h5A, 8'h5A, 0, 8'd0);
        vecs[7]  = mk(0, 5'b01000, 3'b011, 8'h11, 8'h22, 8'h00,
                      8'h11, 8'h22, 8'h5A, 1, 8'd1);
        vecs[8]  = mk(0, 5'b00000, 3'b000, 8'h00, 8'h00, 8'h00,
                      8'h11, 8'h22, 8'h5A, 0, 8'd1);
        vecs[9]  = mk(0, 5'b01100, 3'b101, 8'h11, 8'h00, 8'h33,
                      8'h11, 8'h11, 8'h33, 1, 8'd2);
        vecs[10] = mk(0, 5'b00000, 3'b000, 8'h00, 8'h00, 8'h00,
                      8'h11, 8'h11, 8'h33, 0, 8'd2);
        vecs[11] = mk(0, 5'b11111, 3'b010, 8'h00, 8'h77, 8'h00,
                      8'h77, 8'h77, 8'h77, 0, 8'd2);
        vecs[12] = mk(1, 5'b11111, 3'b111, 8'h01, 8'h02, 8'h03,
                      8'hFF, 8'hFF, 8'hFF, 0, 8'd0);

        drive(1, 5'b0, 3'b0, 8'h0, 8'h0, 8'h0);
        tick();

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rst, vecs[i].sw, vecs[i].oe,
                  vecs[i].d0, vecs[i].d1, vecs[i].d2);
            tick();
            chk($sformatf("vec%0d db0", i), db0_out, vecs[i].e0);
            chk($sformatf("vec%0d db1", i), db1_out, vecs[i].e1);
            chk($sformatf("vec%0d db2", i), db2_out, vecs[i].e2);
            chk($sformatf("vec%0d cont", i), {7'b0, contention},
                {7'b0, vecs[i].ec});
            chk($sformatf("vec%0d cnt", i), contention_cnt, vecs[i].ecnt);
        end

        // Saturation: contend every cycle, counter stops at FF.
        drive(0, 5'b01000, 3'b011, 8'h11, 8'h22, 8'h00);
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 254) chk("sat cnt 254", contention_cnt, 8'hFE);
            if (i == 255) chk("sat cnt 255", contention_cnt, 8'hFF);
        end
        chk("sat cnt 300", contention_cnt, 8'hFF);
        chk("sat cont", {7'b0, contention}, 8'h01);
        chk("sat db1", db1_out, 8'h22);

        // Reset mid-run wins over contended inputs.
        reset = 1'b1;
        tick();
        chk("rst db0", db0_out, 8'hFF);
        chk("rst db1", db1_out, 8'hFF);
        chk("rst db2", db2_out, 8'hFF);
        chk("rst cont", {7'b0, contention}, 8'h00);
        chk("rst cnt", contention_cnt, 8'h00);
        reset = 1'b0;
        tick();
        chk("post rst cnt", contention_cnt, 8'h01);

        // Random stimulus against the model.
        drive(1, 5'b0, 3'b0, 8'h0, 8'h0, 8'h0);
        model_clock();
        tick();
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 59) == 0), 5'($urandom),
                  3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            model_clock();
            tick();
            chk("rnd db0", db0_out, m_db[0]);
            chk("rnd db1", db1_out, m_db[1]);
            chk("rnd db2", db2_out, m_db[2]);
            chk("rnd cont", {7'b0, contention}, {7'b0, m_cont});
            chk("rnd cnt", contention_cnt, 8'(m_cnt));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
